// File: rtl/counter_sequencer.sv
// Start/stop/load controlled up/down counter with compare match and one-shot completion.
// Define COUNTER_SEQUENCER_PRESCALE_EN to build in the clock prescaler; otherwise it steps every RUN clock.
module counter_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             dir,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             match,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10,
    S_DONE = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             match_q, match_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] step_val;
  logic             run_ok;
  logic             pre_clr;
  logic             pre_adv;
  logic             tick_c;

`ifdef COUNTER_SEQUENCER_PRESCALE_EN
  logic [PRE_W-1:0] pre_q;

  // Prescaler: wraps naturally at 2^PRE_W if prescale is lowered below its current value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else if (pre_clr) begin
      pre_q <= '0;
    end else if (pre_adv) begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  assign tick_c = (pre_q == prescale);
`else
  logic unused_prescale;

  assign tick_c          = 1'b1;
  assign unused_prescale = ^{prescale, pre_clr, pre_adv};
`endif

  assign step_val = dir ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));

  // Load always updates count; stop > load > start decides the state transition.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    match_d = 1'b0;
    done_d  = 1'b0;
    pre_clr = 1'b0;
    pre_adv = 1'b0;
    run_ok  = (state_q == S_RUN) && !stop && !load;

    if (load) begin
      count_d = load_val;
      pre_clr = 1'b1;
    end else if (run_ok) begin
      if (tick_c) begin
        count_d = step_val;
        pre_clr = 1'b1;
        match_d = (step_val == cmp_val);
      end else begin
        pre_adv = 1'b1;
      end
    end

    if (stop) begin
      if (state_q == S_RUN) state_d = S_HOLD;
    end else if (load) begin
      if (state_q == S_DONE) state_d = S_IDLE;
    end else if (start && (state_q != S_RUN)) begin
      state_d = S_RUN;
    end else if (run_ok && tick_c && match_d && mode) begin
      state_d = S_DONE;
      done_d  = 1'b1;
    end

    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      match_q <= match_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign count = count_q;
  assign match = match_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: a command-level reference model queues expected outputs per edge.
module tb_counter_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       load;
  logic [7:0] load_val;
  logic       mode;
  logic       dir;
  logic [7:0] cmp_val;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       match;
  logic       done;
  logic       busy;
  logic [1:0] state;

  counter_sequencer #(.WIDTH(8), .PRE_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .mode(mode), .dir(dir), .cmp_val(cmp_val),
    .prescale(prescale), .count(count), .match(match), .done(done),
    .busy(busy), .state(state)
  );

  typedef struct packed {
    logic [7:0] cnt;
    logic [1:0] st;
    logic       m;
    logic       d;
    logic       b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_st   = 0;
  int   m_cnt  = 0;
  int   m_pre  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: one edge of behaviour computed from the command rules.
  task automatic model_edge();
    exp_t e;
    int   ps;
    bit   step;
    e = '0;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_pre = 0;
    end else begin
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
      ps = int'(prescale);
`else
      ps = 0;
`endif
      step = (m_st == 1) && !stop && !load && (m_pre == ps);
      if (load) begin
        m_cnt = int'(load_val);
        m_pre = 0;
      end else if (m_st == 1 && !stop) begin
        if (step) begin
          m_pre = 0;
          m_cnt = (m_cnt + (dir ? 255 : 1)) % 256;
          if (m_cnt == int'(cmp_val)) e.m = 1'b1;
        end else begin
          m_pre = (m_pre + 1) % 16;
        end
      end
      if (stop) begin
        if (m_st == 1) m_st = 2;
      end else if (load) begin
        if (m_st == 3) m_st = 0;
      end else if (start && m_st != 1) begin
        m_st = 1;
      end else if (step && e.m && mode) begin
        m_st = 3;
        e.d  = 1'b1;
      end
    end
    e.cnt = 8'(m_cnt);
    e.st  = 2'(m_st);
    e.b   = (m_st == 1);
    exp_q.push_back(e);
  endtask

  // Inputs are set just after a negedge; this predicts the coming edge and moves to the next negedge.
  task automatic tick();
    model_edge();
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    load  = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count", int'(count), int'(e.cnt));
        chk("state", int'(state), int'(e.st));
        chk("match", int'(match), int'(e.m));
        chk("done",  int'(done),  int'(e.d));
        chk("busy",  int'(busy),  int'(e.b));
      end
    end
  end

  initial begin : driver
    rst = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; load_val = 8'h00;
    mode = 1'b0; dir = 1'b0; cmp_val = 8'h80; prescale = 4'd0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Free-run up from reset.
    start = 1'b1; tick();
    repeat (4) tick();

    // Wrap through 0xFF.
    load = 1'b1; load_val = 8'hFE; tick();
    start = 1'b1; tick();
    repeat (4) tick();

    // One-shot to cmp_val=5 with prescale=3.
    stop = 1'b1; tick();
    load = 1'b1; load_val = 8'h00; tick();
    mode = 1'b1; cmp_val = 8'h05; prescale = 4'd3;
    start = 1'b1; tick();
    repeat (30) tick();
    chk("oneshot_state", int'(state), 3);
    chk("oneshot_count", int'(count), 5);

    // Stop and load together during RUN, then resume.
    mode = 1'b0; cmp_val = 8'h80; prescale = 4'd0;
    start = 1'b1; tick();
    repeat (2) tick();
    stop = 1'b1; load = 1'b1; load_val = 8'h40; tick();
    chk("stopload_state", int'(state), 2);
    chk("stopload_count", int'(count), 8'h40);
    repeat (2) tick();
    start = 1'b1; tick();
    repeat (3) tick();

    // Count down through zero.
    stop = 1'b1; tick();
    load = 1'b1; load_val = 8'h00; tick();
    dir = 1'b1; start = 1'b1; tick();
    repeat (3) tick();

    // Asynchronous reset between edges while running.
    #2 rst = 1'b1;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_state", int'(state), 0);
    chk("async_busy",  int'(busy),  0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    dir = 1'b0; start = 1'b1; tick();
    repeat (2) tick();

    // Randomized commands and configuration.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      load  = ($urandom_range(0, 11) == 0);
      load_val = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) dir  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) cmp_val = 8'((m_cnt + int'($urandom_range(0, 6)) + 253) % 256);
      if ($urandom_range(0, 31) == 0) prescale = 4'($urandom_range(0, 2));
      tick();
    end

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
